// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU control encodings and legality check used by the ALU share arbiter.
package alu_share_arbiter_pkg;

    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND   = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR    = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR   = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = 4'b1000;

    function automatic logic is_legal_alu_ctrl(input logic [ALU_CTRL_W-1:0] ctrl);
        return ctrl <= ALU_PASSB;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// 32-bit integer ALU, purely combinational, wrap-around arithmetic.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
(
    input  logic [31:0]           a,
    input  logic [31:0]           b,
    input  logic [ALU_CTRL_W-1:0] ctrl,
    output logic [31:0]           y
);

    always_comb begin
        y = '0;
        case (ctrl)
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_ADD:   y = a + b;
            ALU_XOR:   y = a ^ b;
            ALU_NOR:   y = ~(a | b);
            ALU_SLTU:  y = {31'b0, a < b};
            ALU_SUB:   y = a - b;
            ALU_SLT:   y = {31'b0, $signed(a) < $signed(b)};
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two issue lanes, feeding a single
// registered result stage with its own valid/ready handshake to writeback.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [31:0]           req0_a,
    input  logic [31:0]           req0_b,
    input  logic [ALU_CTRL_W-1:0] req0_ctrl,
    input  logic [TAG_W-1:0]      req0_tag,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [31:0]           req1_a,
    input  logic [31:0]           req1_b,
    input  logic [ALU_CTRL_W-1:0] req1_ctrl,
    input  logic [TAG_W-1:0]      req1_tag,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_data,
    output logic [TAG_W-1:0]      res_tag,
    output logic                  res_lane,
    output logic                  res_illegal,
    output logic [CNT_W-1:0]      grant_cnt0,
    output logic [CNT_W-1:0]      grant_cnt1
);

    logic                  rr_last;
    logic                  stage_free;
    logic                  grant_lane;
    logic                  accept;
    logic [31:0]           sel_a;
    logic [31:0]           sel_b;
    logic [ALU_CTRL_W-1:0] sel_ctrl;
    logic [TAG_W-1:0]      sel_tag;
    logic                  sel_legal;
    logic [31:0]           alu_y;

    assign stage_free = ~res_valid | res_ready;

    // On contention the lane that did not win last time is chosen.
    always_comb begin
        grant_lane = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_lane = ~rr_last;
        end else if (req1_valid) begin
            grant_lane = 1'b1;
        end
    end

    assign req0_ready = ~reset & stage_free & req0_valid & ~grant_lane;
    assign req1_ready = ~reset & stage_free & req1_valid & grant_lane;
    assign accept     = req0_ready | req1_ready;

    assign sel_a     = grant_lane ? req1_a    : req0_a;
    assign sel_b     = grant_lane ? req1_b    : req0_b;
    assign sel_ctrl  = grant_lane ? req1_ctrl : req0_ctrl;
    assign sel_tag   = grant_lane ? req1_tag  : req0_tag;
    assign sel_legal = is_legal_alu_ctrl(sel_ctrl);

    alu_share_arbiter_alu u_alu (
        .a    (sel_a),
        .b    (sel_b),
        .ctrl (sel_ctrl),
        .y    (alu_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_tag     <= '0;
            res_lane    <= 1'b0;
            res_illegal <= 1'b0;
            grant_cnt0  <= '0;
            grant_cnt1  <= '0;
            rr_last     <= 1'b1;
        end else if (accept) begin
            res_valid   <= 1'b1;
            res_data    <= sel_legal ? alu_y : 32'd0;
            res_tag     <= sel_tag;
            res_lane    <= grant_lane;
            res_illegal <= ~sel_legal;
            rr_last     <= grant_lane;
            if (!grant_lane && grant_cnt0 != '1) begin
                grant_cnt0 <= grant_cnt0 + 1'b1;
            end
            if (grant_lane && grant_cnt1 != '1) begin
                grant_cnt1 <= grant_cnt1 + 1'b1;
            end
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed vector bench for alu_share_arbiter; a second instance with 2-bit
// counters shares the same stimulus to exercise counter saturation.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        v0, v1, rr;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  c0, c1;
    logic [4:0]  t0, t1;

    logic        r0, r1, res_valid, res_lane, res_ill;
    logic [31:0] res_data;
    logic [4:0]  res_tag;
    logic [15:0] cnt0, cnt1;

    logic        s_r0, s_r1, s_valid, s_lane, s_ill;
    logic [31:0] s_data;
    logic [4:0]  s_tag;
    logic [1:0]  s_cnt0, s_cnt1;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_c0 = 0;
    int exp_c1 = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.TAG_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_ctrl(c0), .req0_tag(t0),
        .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_ctrl(c1), .req1_tag(t1),
        .res_valid(res_valid), .res_ready(rr), .res_data(res_data), .res_tag(res_tag),
        .res_lane(res_lane), .res_illegal(res_ill), .grant_cnt0(cnt0), .grant_cnt1(cnt1)
    );

    alu_share_arbiter #(.TAG_W(5), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset),
        .req0_valid(v0), .req0_ready(s_r0), .req0_a(a0), .req0_b(b0), .req0_ctrl(c0),
        .req0_tag(t0),
        .req1_valid(v1), .req1_ready(s_r1), .req1_a(a1), .req1_b(b1), .req1_ctrl(c1),
        .req1_tag(t1),
        .res_valid(s_valid), .res_ready(rr), .res_data(s_data), .res_tag(s_tag),
        .res_lane(s_lane), .res_illegal(s_ill), .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
    );

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic        rr;
        logic        er0;
        logic        er1;
        logic        ev;
        logic [31:0] edata;
        logic [4:0]  etag;
        logic        elane;
        logic        eill;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Both lanes carry the same operands; tags distinguish them (lane0=7, lane1=3).
    task automatic drive(input logic dv0, input logic dv1, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] ctrl, input logic drr);
        v0 = dv0; v1 = dv1; rr = drr;
        a0 = a; b0 = b; c0 = ctrl; t0 = 5'd7;
        a1 = a; b1 = b; c1 = ctrl; t1 = 5'd3;
    endtask

    task automatic check_cnts(input string name);
        check({name, " grant_cnt0"}, {16'd0, cnt0}, exp_c0);
        check({name, " grant_cnt1"}, {16'd0, cnt1}, exp_c1);
        check({name, " small_cnt1"}, {30'd0, s_cnt1}, (exp_c1 > 3) ? 3 : exp_c1);
    endtask

    initial begin
        vecs[0]  = '{1, 0, 32'd5,         32'd3,         4'h2, 1, 1, 0, 1, 32'd8,         5'd7, 0, 0};
        vecs[1]  = '{1, 0, 32'hFFFF_FFFF, 32'd1,         4'h7, 1, 1, 0, 1, 32'd1,         5'd7, 0, 0};
        vecs[2]  = '{1, 0, 32'hFFFF_FFFF, 32'd1,         4'h5, 1, 1, 0, 1, 32'd0,         5'd7, 0, 0};
        vecs[3]  = '{1, 0, 32'hFFFF_FFFF, 32'd1,         4'hA, 1, 1, 0, 1, 32'd0,         5'd7, 0, 1};
        vecs[4]  = '{0, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h0, 1, 0, 1, 1, 32'hF000_F000, 5'd3, 1, 0};
        vecs[5]  = '{0, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h1, 1, 0, 1, 1, 32'hFFF0_FFF0, 5'd3, 1, 0};
        vecs[6]  = '{0, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h3, 1, 0, 1, 1, 32'h0FF0_0FF0, 5'd3, 1, 0};
        vecs[7]  = '{1, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h4, 1, 1, 0, 1, 32'h000F_000F, 5'd7, 0, 0};
        vecs[8]  = '{1, 0, 32'd3,         32'd5,         4'h6, 1, 1, 0, 1, 32'hFFFF_FFFE, 5'd7, 0, 0};
        vecs[9]  = '{1, 0, 32'hDEAD_BEEF, 32'h1234_5678, 4'h8, 1, 1, 0, 1, 32'h1234_5678, 5'd7, 0, 0};
        vecs[10] = '{1, 0, 32'hFFFF_FFFF, 32'd2,         4'h2, 1, 1, 0, 1, 32'd1,         5'd7, 0, 0};
        vecs[11] = '{0, 1, 32'd9,         32'd9,         4'hF, 1, 0, 1, 1, 32'd0,         5'd3, 1, 1};
        vecs[12] = '{1, 1, 32'd1,         32'd2,         4'h2, 1, 1, 0, 1, 32'd3,         5'd7, 0, 0};
        vecs[13] = '{1, 1, 32'd1,         32'd2,         4'h2, 1, 0, 1, 1, 32'd3,         5'd3, 1, 0};
        vecs[14] = '{1, 1, 32'd1,         32'd2,         4'h2, 1, 1, 0, 1, 32'd3,         5'd7, 0, 0};
        vecs[15] = '{0, 0, 32'd0,         32'd0,         4'h0, 1, 0, 0, 0, 32'd0,         5'd0, 0, 0};

        // Reset state; an op is offered during reset and must not be taken.
        reset = 1'b1;
        drive(1, 1, 32'd1, 32'd1, 4'h2, 1);
        #1;
        check("reset req0_ready", {31'd0, r0}, 0);
        check("reset req1_ready", {31'd0, r1}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset res_valid", {31'd0, res_valid}, 0);
        check("reset res_data", res_data, 0);
        check("reset res_tag", {27'd0, res_tag}, 0);
        check("reset res_lane", {31'd0, res_lane}, 0);
        check("reset res_illegal", {31'd0, res_ill}, 0);
        check_cnts("reset");
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].v0, vecs[i].v1, vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].rr);
            #1;
            check($sformatf("vec%0d req0_ready", i), {31'd0, r0}, {31'd0, vecs[i].er0});
            check($sformatf("vec%0d req1_ready", i), {31'd0, r1}, {31'd0, vecs[i].er1});
            if (vecs[i].er0) exp_c0++;
            if (vecs[i].er1) exp_c1++;
            @(posedge clk); #1;
            check($sformatf("vec%0d res_valid", i), {31'd0, res_valid}, {31'd0, vecs[i].ev});
            if (vecs[i].ev) begin
                check($sformatf("vec%0d res_data", i), res_data, vecs[i].edata);
                check($sformatf("vec%0d res_tag", i), {27'd0, res_tag}, {27'd0, vecs[i].etag});
                check($sformatf("vec%0d res_lane", i), {31'd0, res_lane}, {31'd0, vecs[i].elane});
                check($sformatf("vec%0d res_illegal", i), {31'd0, res_ill},
                      {31'd0, vecs[i].eill});
            end
            check_cnts($sformatf("vec%0d", i));
        end

        // Backpressure: lane0 result held while both lanes wait.
        drive(1, 0, 32'd10, 32'd20, 4'h2, 0);
        #1;
        check("bp accept req0_ready", {31'd0, r0}, 1);
        exp_c0++;
        @(posedge clk); #1;
        drive(1, 1, 32'd1, 32'd1, 4'h2, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d req0_ready", k), {31'd0, r0}, 0);
            check($sformatf("bp%0d req1_ready", k), {31'd0, r1}, 0);
            check($sformatf("bp%0d res_valid", k), {31'd0, res_valid}, 1);
            check($sformatf("bp%0d res_data", k), res_data, 32'd30);
            check($sformatf("bp%0d res_tag", k), {27'd0, res_tag}, 32'd7);
            check($sformatf("bp%0d res_lane", k), {31'd0, res_lane}, 0);
            @(posedge clk);
        end
        #1;
        rr = 1'b1;
        #1;
        check("bp release req1_ready", {31'd0, r1}, 1);
        check("bp release req0_ready", {31'd0, r0}, 0);
        exp_c1++;
        @(posedge clk); #1;
        check("bp release res_valid", {31'd0, res_valid}, 1);
        check("bp release res_data", res_data, 32'd2);
        check("bp release res_tag", {27'd0, res_tag}, 32'd3);
        check("bp release res_lane", {31'd0, res_lane}, 1);
        check_cnts("bp release");

        // Reset while a result is pending and both lanes are offering.
        drive(1, 1, 32'd4, 32'd4, 4'h2, 0);
        reset = 1'b1;
        #1;
        check("midrst req0_ready", {31'd0, r0}, 0);
        check("midrst req1_ready", {31'd0, r1}, 0);
        @(posedge clk); #1;
        exp_c0 = 0;
        exp_c1 = 0;
        check("midrst res_valid", {31'd0, res_valid}, 0);
        check_cnts("midrst");
        check("midrst small_cnt0", {30'd0, s_cnt0}, 0);
        reset = 1'b0;
        rr = 1'b1;
        #1;
        check("postrst req0_ready", {31'd0, r0}, 1);
        check("postrst req1_ready", {31'd0, r1}, 0);
        @(posedge clk); #1;
        check("postrst res_lane", {31'd0, res_lane}, 0);
        check("postrst res_data", res_data, 32'd8);
        drive(0, 0, 32'd0, 32'd0, 4'h0, 1);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
